// File: rtl/snn_param_bank_if.sv
// snn_param_bank_if: host-side load/commit/read bus of the double-buffered parameter bank
interface snn_param_bank_if #(
  parameter int DEPTH = 101,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0] addr;
  logic write_enable;
  logic stream_start;
  logic stream_valid;
  logic commit;
  logic rd_sel;
  logic [WIDTH-1:0] data_out;
  logic [DEPTH*WIDTH-1:0] all_data_out;
  logic [AW-1:0] stream_ptr;
  logic load_done;
  logic addr_err;
  logic commit_ack;
  modport master (
    output data_in, addr, write_enable, stream_start, stream_valid, commit, rd_sel,
    input data_out, all_data_out, stream_ptr, load_done, addr_err, commit_ack
  );
  modport slave (
    input data_in, addr, write_enable, stream_start, stream_valid, commit, rd_sel,
    output data_out, all_data_out, stream_ptr, load_done, addr_err, commit_ack
  );
endinterface

// File: rtl/snn_param_bank.sv
// snn_param_bank: shadow/active configuration store; host loads shadow, commit publishes it atomically
module snn_param_bank #(
  parameter int DEPTH = 101,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  snn_param_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [WIDTH-1:0] active [DEPTH];
  logic addr_ok;
  assign addr_ok = {1'b0, bus.addr} < DEPTH_X;
  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_flat
      assign bus.all_data_out[j*WIDTH +: WIDTH] = active[j];
    end
  endgenerate
  // commit copies pre-edge shadow, so a same-cycle write lands only in shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
      bus.data_out <= '0;
      bus.stream_ptr <= '0;
      bus.load_done <= 1'b0;
      bus.addr_err <= 1'b0;
      bus.commit_ack <= 1'b0;
    end else begin
      bus.commit_ack <= bus.commit;
      if (bus.commit) active <= shadow;
      bus.data_out <= addr_ok ? (bus.rd_sel ? shadow[bus.addr] : active[bus.addr]) : '0;
      if (bus.write_enable && addr_ok) shadow[bus.addr] <= bus.data_in;
      if (bus.stream_start) begin
        bus.stream_ptr <= '0;
        bus.load_done <= 1'b0;
        bus.addr_err <= 1'b0;
      end else if (bus.write_enable) begin
        if (!addr_ok) bus.addr_err <= 1'b1;
      end else if (bus.stream_valid) begin
        shadow[bus.stream_ptr] <= bus.data_in;
        bus.stream_ptr <= (bus.stream_ptr == LAST) ? '0 : bus.stream_ptr + AW'(1);
        if (bus.stream_ptr == LAST) bus.load_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_snn_param_bank.sv
// tb_snn_param_bank: table-driven and randomized checks of snn_param_bank against a bank model
module tb_snn_param_bank;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  snn_param_bank_if #(.DEPTH(101), .WIDTH(8)) bus_a();
  snn_param_bank_if #(.DEPTH(16), .WIDTH(12)) bus_b();
  snn_param_bank #(.DEPTH(101), .WIDTH(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  snn_param_bank #(.DEPTH(16), .WIDTH(12)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int passed = 0;
  int total = 0;
  logic [7:0] sh [101];
  logic [7:0] ac [101];
  int ptr;
  logic done, err, exp_ack;
  logic [7:0] exp_dout;

  typedef struct {
    logic [7:0] d; logic [6:0] a; logic we, ss, sv, cm, rs;
    logic [7:0] dout; logic [6:0] ptr; logic err, ack;
  } vec_t;
  vec_t vt [23];

  task automatic check(input string n, input logic [1023:0] act, input logic [1023:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic logic [1023:0] flat_ac();
    logic [1023:0] r = '0;
    for (int i = 0; i < 101; i++) r[i*8 +: 8] = ac[i];
    return r;
  endfunction

  task automatic check_all();
    check("data_out", 1024'(bus_a.data_out), 1024'(exp_dout));
    check("commit_ack", 1024'(bus_a.commit_ack), 1024'(exp_ack));
    check("stream_ptr", 1024'(bus_a.stream_ptr), 1024'(ptr));
    check("load_done", 1024'(bus_a.load_done), 1024'(done));
    check("addr_err", 1024'(bus_a.addr_err), 1024'(err));
    check("all_data_out", 1024'(bus_a.all_data_out), flat_ac());
  endtask

  task automatic idle_inputs();
    bus_a.write_enable = 0; bus_a.stream_start = 0; bus_a.stream_valid = 0; bus_a.commit = 0;
    bus_b.write_enable = 0; bus_b.stream_start = 0; bus_b.stream_valid = 0; bus_b.commit = 0;
    bus_b.rd_sel = 0; bus_b.addr = '0; bus_b.data_in = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    for (int i = 0; i < 101; i++) begin sh[i] = 0; ac[i] = 0; end
    ptr = 0; done = 0; err = 0; exp_ack = 0; exp_dout = 0;
    #1 reset = 0;
    check_all();
  endtask

  // one clock of bank A: the model applies the documented per-cycle rules to pre-edge state
  task automatic step(input logic [7:0] d, input logic [6:0] a,
                      input logic we, ss, sv, cm, rs);
    bus_a.data_in = d; bus_a.addr = a; bus_a.write_enable = we; bus_a.stream_start = ss;
    bus_a.stream_valid = sv; bus_a.commit = cm; bus_a.rd_sel = rs;
    @(posedge clk);
    exp_dout = (a < 101) ? (rs ? sh[a] : ac[a]) : 8'h00;
    exp_ack = cm;
    if (cm) ac = sh;
    if (ss) begin ptr = 0; done = 0; err = 0; end
    if (we) begin
      if (a < 101) sh[a] = d;
      else if (!ss) err = 1;
    end else if (sv && !ss) begin
      sh[ptr] = d;
      ptr = (ptr + 1) % 101;
      if (ptr == 0) done = 1;
    end
    #1;
    idle_inputs();
    check_all();
  endtask

  logic [191:0] eb;

  initial begin
    vt[0]  = '{8'h5A, 7'd7,   1,0,0,0,0, 8'h00, 7'd0, 0, 0};
    vt[1]  = '{8'h00, 7'd7,   0,0,0,1,0, 8'h00, 7'd0, 0, 1};
    vt[2]  = '{8'hC3, 7'd7,   1,0,0,0,0, 8'h5A, 7'd0, 0, 0};
    vt[3]  = '{8'h00, 7'd7,   0,0,0,0,0, 8'h5A, 7'd0, 0, 0};
    vt[4]  = '{8'h00, 7'd7,   0,0,0,0,1, 8'hC3, 7'd0, 0, 0};
    vt[5]  = '{8'h22, 7'd3,   1,0,0,0,0, 8'h00, 7'd0, 0, 0};
    vt[6]  = '{8'h00, 7'd3,   0,0,0,1,0, 8'h00, 7'd0, 0, 1};
    vt[7]  = '{8'h11, 7'd3,   1,0,0,1,0, 8'h22, 7'd0, 0, 1};
    vt[8]  = '{8'h00, 7'd3,   0,0,0,0,0, 8'h22, 7'd0, 0, 0};
    vt[9]  = '{8'h00, 7'd3,   0,0,0,1,0, 8'h22, 7'd0, 0, 1};
    vt[10] = '{8'h00, 7'd3,   0,0,0,0,0, 8'h11, 7'd0, 0, 0};
    vt[11] = '{8'hFF, 7'd101, 1,0,0,0,0, 8'h00, 7'd0, 1, 0};
    vt[12] = '{8'hFF, 7'd127, 1,0,0,0,0, 8'h00, 7'd0, 1, 0};
    vt[13] = '{8'h00, 7'd120, 0,0,0,0,1, 8'h00, 7'd0, 1, 0};
    vt[14] = '{8'h44, 7'd0,   0,0,1,0,1, 8'h00, 7'd1, 1, 0};
    vt[15] = '{8'h45, 7'd0,   0,0,1,0,1, 8'h44, 7'd2, 1, 0};
    vt[16] = '{8'h46, 7'd0,   0,0,1,0,1, 8'h44, 7'd3, 1, 0};
    vt[17] = '{8'h47, 7'd0,   0,0,1,0,1, 8'h44, 7'd4, 1, 0};
    vt[18] = '{8'h77, 7'd10,  1,0,1,0,1, 8'h00, 7'd4, 1, 0};
    vt[19] = '{8'h00, 7'd10,  0,0,0,0,1, 8'h77, 7'd4, 1, 0};
    vt[20] = '{8'h00, 7'd4,   0,0,0,0,1, 8'h00, 7'd4, 1, 0};
    vt[21] = '{8'h55, 7'd0,   0,1,1,0,1, 8'h44, 7'd0, 0, 0};
    vt[22] = '{8'h00, 7'd0,   0,0,0,0,1, 8'h44, 7'd0, 0, 0};
    bus_a.rd_sel = 0; bus_a.addr = '0; bus_a.data_in = '0;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 23; i++) begin
      step(vt[i].d, vt[i].a, vt[i].we, vt[i].ss, vt[i].sv, vt[i].cm, vt[i].rs);
      check($sformatf("vec%0d data_out", i), 1024'(bus_a.data_out), 1024'(vt[i].dout));
      check($sformatf("vec%0d stream_ptr", i), 1024'(bus_a.stream_ptr), 1024'(vt[i].ptr));
      check($sformatf("vec%0d addr_err", i), 1024'(bus_a.addr_err), 1024'(vt[i].err));
      check($sformatf("vec%0d commit_ack", i), 1024'(bus_a.commit_ack), 1024'(vt[i].ack));
    end
    check("word7 active", 1024'(bus_a.all_data_out[7*8 +: 8]), 1024'(8'hC3));
    check("word3 active", 1024'(bus_a.all_data_out[3*8 +: 8]), 1024'(8'h11));

    do_reset();
    for (int i = 0; i < 101; i++) begin
      step(8'(i + 1), 7'd0, 0, 0, 1, 0, 0);
      if (i == 99) check("load_done early", 1024'(bus_a.load_done), 1024'(0));
    end
    check("load_done full", 1024'(bus_a.load_done), 1024'(1));
    check("ptr wrapped", 1024'(bus_a.stream_ptr), 1024'(0));
    check("active before commit", 1024'(bus_a.all_data_out), 1024'(0));
    step(8'h00, 7'd0, 0, 0, 0, 1, 0);
    check("word0 after commit", 1024'(bus_a.all_data_out[7:0]), 1024'(8'h01));
    check("word100 after commit", 1024'(bus_a.all_data_out[100*8 +: 8]), 1024'(8'h65));
    check("ack pulse", 1024'(bus_a.commit_ack), 1024'(1));
    step(8'h00, 7'd0, 0, 0, 0, 1, 0);
    check("ack back-to-back", 1024'(bus_a.commit_ack), 1024'(1));
    step(8'h00, 7'd0, 0, 0, 0, 0, 0);
    check("ack drops", 1024'(bus_a.commit_ack), 1024'(0));

    for (int i = 0; i < 50; i++) step(8'(8'hA0 + i), 7'd0, 0, 0, 1, 0, 0);
    step(8'h00, 7'd0, 0, 0, 0, 1, 0);
    do_reset();
    check("reset clears bus", 1024'(bus_a.all_data_out), 1024'(0));
    step(8'h00, 7'd0, 0, 0, 0, 1, 0);
    check("commit after reset", 1024'(bus_a.all_data_out), 1024'(0));

    for (int k = 0; k < 400; k++) begin
      logic ss, we;
      ss = ($urandom_range(0, 31) == 0);
      we = ss ? 1'b0 : ($urandom_range(0, 3) == 0);
      step(8'($urandom), 7'($urandom_range(0, 127)), we, ss, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    do_reset();
    eb = '0;
    for (int i = 0; i < 16; i++) begin
      bus_b.data_in = 12'(i * 37 + 12'hA00);
      bus_b.stream_valid = 1;
      eb[i*12 +: 12] = 12'(i * 37 + 12'hA00);
      @(posedge clk); #1;
      idle_inputs();
      check("b stream_ptr", 1024'(bus_b.stream_ptr), 1024'((i + 1) % 16));
      check("b load_done", 1024'(bus_b.load_done), 1024'(i == 15));
    end
    check("b bus before commit", 1024'(bus_b.all_data_out), 1024'(0));
    bus_b.commit = 1;
    @(posedge clk); #1;
    idle_inputs();
    check("b commit_ack", 1024'(bus_b.commit_ack), 1024'(1));
    check("b bus after commit", 1024'(bus_b.all_data_out), 1024'(eb));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/snn_param_bank.md
Name: snn_param_bank

Overview:
- Parametrised, double-buffered configuration byte store for the SNN core. It holds thresholds, decay values, weights and control bytes.
- Host bytes land in a shadow bank, written either by random-access address or by an auto-incrementing stream.
- The active bank drives the flat `all_data_out` bus seen by the neuron layers. It changes only on an explicit `commit`, so the network never sees a half-loaded configuration.
- Sits between the SPI/byte-load front end and the neuron arrays.

Parameters:
- DEPTH, 101, number of bytes (words) stored; must be >= 2.
- WIDTH, 8, bits per word.
- AW, $clog2(DEPTH), address/pointer width. Localparam, derived, not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- data_in  in  WIDTH  write data for both random and stream writes.
- addr  in  AW  random-access write address and read address.
- write_enable  in  1  random write of data_in to shadow[addr].
- stream_start  in  1  restart stream load: pointer to 0, clear load_done/addr_err.
- stream_valid  in  1  stream write of data_in to shadow[stream_ptr], pointer advances.
- commit  in  1  copy whole shadow bank into active bank.
- rd_sel  in  1  read source: 0 = active, 1 = shadow.
- data_out  out  WIDTH  registered read data.
- all_data_out  out  DEPTH*WIDTH  active bank, word j on bits [j*WIDTH +: WIDTH].
- stream_ptr  out  AW  next stream write index.
- load_done  out  1  sticky: stream wrote index DEPTH-1.
- addr_err  out  1  sticky: random write with addr >= DEPTH.
- commit_ack  out  1  one-cycle pulse the cycle after a commit.

Behaviour:
- Reset (reset=1 at posedge) clears to 0:
  - every shadow and active word;
  - data_out, all_data_out, stream_ptr, load_done, addr_err, commit_ack.
- Reset overrides all other inputs that cycle.
- Shadow-bank write priority per cycle, highest first:
  1. stream_start: stream_ptr<=0, load_done<=0, addr_err<=0. No shadow write; any stream_valid that cycle is ignored. A write_enable that cycle still performs its random write.
  2. write_enable:
     - addr < DEPTH: shadow[addr]<=data_in.
     - addr >= DEPTH: no write, addr_err<=1.
     - Any stream_valid that cycle is dropped and stream_ptr holds.
  3. stream_valid: shadow[stream_ptr]<=data_in.
     - stream_ptr<DEPTH-1: stream_ptr increments.
     - stream_ptr==DEPTH-1: stream_ptr wraps to 0 and load_done<=1.
     - Further stream writes after wrap overwrite from index 0; load_done stays 1.
- Commit:
  - On commit=1, every active[j]<=shadow[j] using the shadow values before this cycle's edge.
  - A write in the same cycle as commit reaches the shadow bank only; it is not in the active bank until the next commit.
  - all_data_out reflects the new active bank one cycle after commit is sampled.
  - commit_ack=1 for exactly that one cycle.
  - Back-to-back commits are legal; commit_ack stays high for each.
  - Commit does not touch stream_ptr, load_done or addr_err.
- Read path, every cycle (no enable):
  - data_out <= rd_sel ? shadow[addr] : active[addr]; 1-cycle latency.
  - addr >= DEPTH: data_out <= 0; addr_err is not set by reads.
  - A read in the same cycle as a write to that address returns the old value.
- all_data_out is a direct wire from the active registers; no extra latency beyond the commit edge.
- Active bank is never written except by commit or reset.
- Reset asserted mid-stream or mid-load discards everything; the host must reload and recommit.
- Width rules:
  - data_in is stored unmodified.
  - stream_ptr comparison uses DEPTH-1 in AW bits.
  - For non-power-of-two DEPTH, pointer values >= DEPTH are unreachable.

Test Plan:
- Reset then stream load: 101 stream_valid pulses with data=index+1 -> stream_ptr 0..100 then 0, load_done=1 after 101st. all_data_out still all 0 until commit; after commit, word 0=0x01, word 100=0x65, commit_ack one cycle.
- Double buffering: active holds 0x5A at addr 7; random write 0xC3 to addr 7 without commit.
  - rd_sel=0 -> data_out=0x5A; rd_sel=1 -> 0xC3, each one cycle after addr applied.
  - all_data_out word 7 stays 0x5A until commit, then becomes 0xC3.
- Simultaneous write+commit: write 0x11 to addr 3 with commit in the same cycle (shadow[3] was 0x22) -> active word 3=0x22; a second commit gives 0x11.
- Priority collisions:
  - write_enable(addr 10, 0x77) with stream_valid at ptr 4 -> shadow[10]=0x77, shadow[4] unchanged, stream_ptr stays 4.
  - stream_start with stream_valid -> ptr=0, no write, load_done and addr_err cleared.
- Out of range: write_enable with addr=101 and addr=127 -> no word changes, addr_err=1 and sticky. Reading addr 120 -> data_out=0. stream_start clears addr_err.
- Reset mid-operation: assert reset after 50 stream bytes and one commit -> next cycle all outputs 0, stream_ptr=0, load_done=0; a commit afterwards keeps all_data_out at 0.
- Parametrisation: rerun the first scenario with DEPTH=16, WIDTH=12 -> wrap at ptr 15, 12-bit words intact on a 192-bit bus.
